// File: rtl/fetdriver_seq_pkg.sv
// Shared types for the multi-channel half-bridge gate sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package fetdriver_seq_pkg;

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_DT_H = 3'd1,
        S_HS   = 3'd2,
        S_DT_L = 3'd3,
        S_LS   = 3'd4,
        S_FLT  = 3'd5
    } fet_state_t;

    localparam int DEF_TIMEOUT = 16;

    // Counter must be able to hold TIMEOUT itself (saturation value).
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/fetdriver_seq_ch.sv
// One half-bridge channel: dead-time FSM, confirmation counter, 2-flop status synchronisers.
// Latency: gates registered, change on the edge after a request; status sensing adds 2 cycles.
// Backpressure: none; missing gate confirmation within TIMEOUT latches the channel into S_FLT.
module fetdriver_seq_ch
    import fetdriver_seq_pkg::*;
#(
    parameter int DEADTIME = 4,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int CNT_W    = cnt_width(TIMEOUT)
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic fetin,
    input  logic gate_status_hs,
    input  logic gate_status_ls,
    input  logic fault_clr,
    output logic gate_hs,
    output logic gate_ls,
    output logic fault,
    output logic dt_active
);

    localparam logic [CNT_W-1:0] DT_M1   = CNT_W'(DEADTIME - 1);
    localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    fet_state_t       state_q;
    fet_state_t       state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       hs_sync;
    logic [1:0]       ls_sync;
    logic             conf_q;
    logic             hs_ok;
    logic             ls_ok;

    assign hs_ok = hs_sync[1];
    assign ls_ok = ls_sync[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hs_sync <= '0;
            ls_sync <= '0;
        end else begin
            hs_sync <= {hs_sync[0], gate_status_hs};
            ls_sync <= {ls_sync[0], gate_status_ls};
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (state_q == S_FLT) begin
            if (fault_clr) state_nxt = S_OFF;
        end else if (!en) begin
            state_nxt = S_OFF;
        end else begin
            case (state_q)
                S_OFF:  state_nxt = fetin ? S_DT_H : S_DT_L;
                S_DT_H: begin
                    if (!fetin)                        state_nxt = S_DT_L;
                    else if (cnt_q >= DT_M1 && !ls_ok) state_nxt = S_HS;
                    else if (cnt_q == TO_M1)           state_nxt = S_FLT;
                end
                S_HS: begin
                    if (!fetin)                                     state_nxt = S_DT_L;
                    else if (!conf_q && !hs_ok && cnt_q == TO_M1)  state_nxt = S_FLT;
                end
                S_DT_L: begin
                    if (fetin)                         state_nxt = S_DT_H;
                    else if (cnt_q >= DT_M1 && !hs_ok) state_nxt = S_LS;
                    else if (cnt_q == TO_M1)           state_nxt = S_FLT;
                end
                S_LS: begin
                    if (fetin)                                      state_nxt = S_DT_H;
                    else if (!conf_q && !ls_ok && cnt_q == TO_M1)  state_nxt = S_FLT;
                end
                default: state_nxt = S_OFF;
            endcase
        end
    end

    // conf_q remembers that the driven gate was seen on, so it is not rechecked.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            conf_q  <= 1'b0;
            gate_hs <= 1'b0;
            gate_ls <= 1'b0;
        end else begin
            state_q <= state_nxt;
            gate_hs <= (state_nxt == S_HS);
            gate_ls <= (state_nxt == S_LS);
            if (state_nxt != state_q) begin
                cnt_q  <= '0;
                conf_q <= 1'b0;
            end else begin
                if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
                if ((state_q == S_HS && hs_ok) || (state_q == S_LS && ls_ok)) conf_q <= 1'b1;
            end
        end
    end

    assign fault     = (state_q == S_FLT);
    assign dt_active = (state_q == S_DT_H) || (state_q == S_DT_L);

endmodule

// File: rtl/fetdriver_seq.sv
// NUM_CH independent half-bridge sequencers sharing enable and fault clear.
// Latency: gate commands registered, one edge after a request; sensing adds 2 cycles.
// Backpressure: none; busy flags any channel currently inside a dead-time window.
module fetdriver_seq
    import fetdriver_seq_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int DEADTIME = 4,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int CNT_W    = cnt_width(TIMEOUT)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable_fetdriver,
    input  logic              global_fetdriver,
    input  logic [NUM_CH-1:0] fetin,
    input  logic [NUM_CH-1:0] gate_status_hs,
    input  logic [NUM_CH-1:0] gate_status_ls,
    input  logic              fault_clr,
    output logic [NUM_CH-1:0] gate_hs,
    output logic [NUM_CH-1:0] gate_ls,
    output logic [NUM_CH-1:0] fault,
    output logic              busy
);

    logic              en;
    logic [NUM_CH-1:0] dt_active;

    assign en = enable_fetdriver & global_fetdriver;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        fetdriver_seq_ch #(
            .DEADTIME (DEADTIME),
            .TIMEOUT  (TIMEOUT),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk            (clk),
            .resetn         (resetn),
            .en             (en),
            .fetin          (fetin[i]),
            .gate_status_hs (gate_status_hs[i]),
            .gate_status_ls (gate_status_ls[i]),
            .fault_clr      (fault_clr),
            .gate_hs        (gate_hs[i]),
            .gate_ls        (gate_ls[i]),
            .fault          (fault[i]),
            .dt_active      (dt_active[i])
        );
    end

    assign busy = |dt_active;

endmodule

// File: tb/tb_fetdriver_seq.sv
// Directed + randomized check of fetdriver_seq against a behavioural channel model.
module tb_fetdriver_seq;

    localparam int NUM_CH = 2;
    localparam int DT     = 4;
    localparam int TO     = 16;

    localparam int OFF = 0, WH = 1, ONH = 2, WL = 3, ONL = 4, FLT = 5;

    logic              clk = 1'b0;
    logic              resetn;
    logic              enable_fetdriver;
    logic              global_fetdriver;
    logic [NUM_CH-1:0] fetin;
    logic [NUM_CH-1:0] gate_status_hs;
    logic [NUM_CH-1:0] gate_status_ls;
    logic              fault_clr;
    logic [NUM_CH-1:0] gate_hs;
    logic [NUM_CH-1:0] gate_ls;
    logic [NUM_CH-1:0] fault;
    logic              busy;

    always #5 clk = ~clk;

    fetdriver_seq #(
        .NUM_CH   (NUM_CH),
        .DEADTIME (DT),
        .TIMEOUT  (TO)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .enable_fetdriver (enable_fetdriver),
        .global_fetdriver (global_fetdriver),
        .fetin            (fetin),
        .gate_status_hs   (gate_status_hs),
        .gate_status_ls   (gate_status_ls),
        .fault_clr        (fault_clr),
        .gate_hs          (gate_hs),
        .gate_ls          (gate_ls),
        .fault            (fault),
        .busy             (busy)
    );

    int tests = 0;
    int fails = 0;

    // Channel model: mode, unbounded time in mode, confirmation seen, 2-deep sense delay.
    int m_mode [NUM_CH];
    int m_t    [NUM_CH];
    bit m_conf [NUM_CH];
    bit m_hs1  [NUM_CH];
    bit m_hs2  [NUM_CH];
    bit m_ls1  [NUM_CH];
    bit m_ls2  [NUM_CH];
    // Sense behaviour: 0 ideal, 1 hs stuck 0, 2 ls stuck 1, 3 random.
    int sense  [NUM_CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c] = OFF;
            m_t[c]    = 0;
            m_conf[c] = 1'b0;
            m_hs1[c]  = 1'b0;
            m_hs2[c]  = 1'b0;
            m_ls1[c]  = 1'b0;
            m_ls2[c]  = 1'b0;
        end
    endtask

    task automatic model_edge(input bit e, input logic [NUM_CH-1:0] fi, input bit clr,
                              input logic [NUM_CH-1:0] shs, input logic [NUM_CH-1:0] sls);
        for (int c = 0; c < NUM_CH; c++) begin
            int cur;
            int nxt;
            bit toward_h;
            bit own;
            bit other;
            cur      = m_mode[c];
            nxt      = cur;
            toward_h = (cur == WH) || (cur == ONH);
            own      = toward_h ? m_hs2[c] : m_ls2[c];
            other    = toward_h ? m_ls2[c] : m_hs2[c];
            if (cur == FLT) begin
                if (clr) nxt = OFF;
            end else if (!e) begin
                nxt = OFF;
            end else if (cur == OFF) begin
                nxt = fi[c] ? WH : WL;
            end else if (fi[c] != toward_h) begin
                nxt = toward_h ? WL : WH;
            end else if (cur == WH || cur == WL) begin
                if (m_t[c] >= DT - 1 && !other) nxt = toward_h ? ONH : ONL;
                else if (m_t[c] == TO - 1)      nxt = FLT;
            end else if (!(m_conf[c] || own) && m_t[c] == TO - 1) begin
                nxt = FLT;
            end
            if (nxt != cur) begin
                m_t[c]    = 0;
                m_conf[c] = 1'b0;
            end else begin
                m_t[c]++;
                if (cur == ONH || cur == ONL) m_conf[c] = m_conf[c] | own;
            end
            m_mode[c] = nxt;
            m_hs2[c]  = m_hs1[c];
            m_hs1[c]  = shs[c];
            m_ls2[c]  = m_ls1[c];
            m_ls1[c]  = sls[c];
        end
    endtask

    task automatic step();
        bit                e;
        bit                clr;
        bit                exp_busy;
        logic [NUM_CH-1:0] fi;
        logic [NUM_CH-1:0] shs;
        logic [NUM_CH-1:0] sls;
        e   = enable_fetdriver & global_fetdriver;
        clr = fault_clr;
        fi  = fetin;
        shs = gate_status_hs;
        sls = gate_status_ls;
        @(posedge clk);
        #1;
        model_edge(e, fi, clr, shs, sls);
        exp_busy = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("gate_hs[%0d]", c), gate_hs[c], (m_mode[c] == ONH));
            chk($sformatf("gate_ls[%0d]", c), gate_ls[c], (m_mode[c] == ONL));
            chk($sformatf("fault[%0d]", c),   fault[c],   (m_mode[c] == FLT));
            if (m_mode[c] == WH || m_mode[c] == WL) exp_busy = 1'b1;
        end
        chk("busy", busy, exp_busy);
        for (int c = 0; c < NUM_CH; c++) begin
            case (sense[c])
                0: begin gate_status_hs[c] = gate_hs[c]; gate_status_ls[c] = gate_ls[c]; end
                1: begin gate_status_hs[c] = 1'b0;       gate_status_ls[c] = gate_ls[c]; end
                2: begin gate_status_hs[c] = gate_hs[c]; gate_status_ls[c] = 1'b1;       end
                default: begin
                    gate_status_hs[c] = 1'($urandom);
                    gate_status_ls[c] = 1'($urandom);
                end
            endcase
        end
    endtask

    // Step while channel 1 randomly toggles its request.
    task automatic step_r();
        if ($urandom_range(0, 3) == 0) fetin[1] = ~fetin[1];
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bc;
        bit hs_seen;

        // 1: reset with random inputs
        resetn           = 1'b0;
        sense            = '{0, 0};
        model_reset();
        for (int i = 0; i < 4; i++) begin
            enable_fetdriver = 1'($urandom);
            global_fetdriver = 1'($urandom);
            fetin            = NUM_CH'($urandom);
            gate_status_hs   = NUM_CH'($urandom);
            gate_status_ls   = NUM_CH'($urandom);
            fault_clr        = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst_gate_hs", gate_hs, 0);
            chk("rst_gate_ls", gate_ls, 0);
            chk("rst_fault",   fault,   0);
            chk("rst_busy",    busy,    0);
        end
        enable_fetdriver = 1'b0;
        global_fetdriver = 1'b1;
        fault_clr        = 1'b0;
        resetn           = 1'b1;
        step();
        chk("rel_gate_hs", gate_hs, 0);
        chk("rel_gate_ls", gate_ls, 0);
        chk("rel_busy",    busy,    0);

        // 2: low side to high side with dead-time
        enable_fetdriver = 1'b1;
        fetin            = '0;
        repeat (10) step();
        chk("t2_pre_ls", gate_ls[0], 1);
        fetin[0] = 1'b1;
        step();
        chk("t2_ls_fall", gate_ls[0], 0);
        bc = int'(busy);
        k  = 0;
        while (gate_hs[0] !== 1'b1 && k < 20) begin
            step();
            k++;
            bc += int'(busy);
        end
        chk("t2_dt_cycles", k, 4);
        chk("t2_busy_cycles", bc, 4);

        // 5: global enable drop and re-enable
        global_fetdriver = 1'b0;
        step();
        chk("t5_hs_drop", gate_hs[0], 0);
        repeat (3) step();
        global_fetdriver = 1'b1;
        k = 0;
        while (gate_hs[0] !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk("t5_reenable", k, 5);

        // 3: LS status stuck high blocks HS turn-on
        sense[0] = 2;
        fetin[0] = 1'b0;
        repeat (8) step_r();
        chk("t3_pre_ls", gate_ls[0], 1);
        fetin[0] = 1'b1;
        step_r();
        chk("t3_ls_off", gate_ls[0], 0);
        k       = 0;
        hs_seen = 1'b0;
        while (fault[0] !== 1'b1 && k < 40) begin
            step_r();
            k++;
            if (gate_hs[0]) hs_seen = 1'b1;
        end
        chk("t3_fault_lat", k, 16);
        chk("t3_no_hs", hs_seen, 0);
        chk("t3_ch1_ok", fault[1], 0);

        // 4: HS status stuck low after turn-on
        fault_clr = 1'b1;
        step_r();
        fault_clr = 1'b0;
        chk("t4_clr", fault[0], 0);
        sense[0] = 1;
        k = 0;
        while (gate_hs[0] !== 1'b1 && k < 30) begin
            step_r();
            k++;
        end
        chk("t4_reach_hs", gate_hs[0], 1);
        k = 0;
        while (fault[0] !== 1'b1 && k < 40) begin
            step_r();
            k++;
        end
        chk("t4_fault_lat", k, 16);
        chk("t4_hs_drop", gate_hs[0], 0);

        // 6: fault holds through disable, clears on pulse, then resumes
        enable_fetdriver = 1'b0;
        repeat (4) step_r();
        chk("t6_fault_hold", fault[0], 1);
        fault_clr = 1'b1;
        step_r();
        fault_clr = 1'b0;
        chk("t6_clr", fault[0], 0);
        sense[0]         = 0;
        enable_fetdriver = 1'b1;
        k = 0;
        while (gate_hs[0] !== 1'b1 && k < 20) begin
            step_r();
            k++;
        end
        chk("t6_resume", k, 5);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 4) == 0)  fetin[c] = ~fetin[c];
                if ($urandom_range(0, 40) == 0) sense[c] = int'($urandom_range(0, 3));
            end
            enable_fetdriver = ($urandom_range(0, 19) != 0);
            global_fetdriver = ($urandom_range(0, 29) != 0);
            fault_clr        = ($urandom_range(0, 14) == 0);
            step();
        end

        // Asynchronous reset mid-operation
        sense            = '{0, 0};
        enable_fetdriver = 1'b1;
        global_fetdriver = 1'b1;
        fault_clr        = 1'b1;
        step();
        fault_clr = 1'b0;
        fetin     = 2'b01;
        repeat (12) step();
        chk("ar_pre_hs", gate_hs[0], 1);
        chk("ar_pre_ls", gate_ls[1], 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_hs_drop", gate_hs[0], 0);
        chk("ar_ls_drop", gate_ls[1], 0);
        model_reset();
        #3;
        resetn = 1'b1;
        repeat (12) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetdriver_seq.md
Name: fetdriver_seq

Overview:
Parametrised, clocked successor to the single-FET driver control. Sequences NUM_CH half-bridge channels, each with high-side and low-side gates. Per channel it inserts programmable dead-time between gates, confirms each gate transition from the sensed gate status, and latches a fault on confirmation timeout. Sits between the loop/PWM logic (fetin) and the HV level-shifted gate drivers.

Parameters:
NUM_CH, 2, number of half-bridge channels.
DEADTIME, 4, minimum cycles with both gates off before either gate turns on (>=1).
TIMEOUT, 16, max cycles allowed for a gate-status confirmation (>= DEADTIME+3).
CNT_W, $clog2(TIMEOUT+1), counter width (derived).

Ports:
clk  input  1  block clock.
resetn  input  1  async active-low reset.
enable_fetdriver  input  1  local enable, active high.
global_fetdriver  input  1  global enable, active high. Effective en = enable_fetdriver & global_fetdriver.
fetin  input  NUM_CH  per-channel request: 1 = high side on, 0 = low side on.
gate_status_hs  input  NUM_CH  sensed HS gate state, async to clk.
gate_status_ls  input  NUM_CH  sensed LS gate state, async to clk.
fault_clr  input  1  pulse; clears latched faults.
gate_hs  output  NUM_CH  HS gate command.
gate_ls  output  NUM_CH  LS gate command.
fault  output  NUM_CH  latched confirmation fault.
busy  output  1  OR over channels of "in a dead-time state".

Behaviour:
- Reset: all outputs 0; every channel in S_OFF; counters 0; synchronisers cleared.
- gate_status_* pass through a 2-flop synchroniser per bit. All status checks below use synced values, so sensing latency is 2 cycles.
- Per-channel FSM states: S_OFF, S_DT_H, S_HS, S_DT_L, S_LS, S_FLT.
- gate_hs and gate_ls are flops updated on the same edge as the state. gate_hs=1 only in S_HS; gate_ls=1 only in S_LS. Both gates are never 1 together.
- fault=1 only in S_FLT. busy=1 if any channel is in S_DT_H or S_DT_L.
- The counter clears on every state change and otherwise increments, saturating at TIMEOUT.
- en=0, in any state except S_FLT: next state is S_OFF, so gates drop on the next edge. en has priority over every other transition. S_FLT is not left on en=0.
- S_OFF with en=1: fetin=1 goes to S_DT_H; fetin=0 goes to S_DT_L.
- S_DT_H (both gates off):
  - If fetin=0, go to S_DT_L (counter restarts).
  - Else if cnt >= DEADTIME-1 and synced ls_status=0, go to S_HS.
  - Else if cnt == TIMEOUT-1, go to S_FLT.
- S_HS:
  - If fetin=0, go to S_DT_L.
  - Else, if synced hs_status is not yet 1 by cnt == TIMEOUT-1, go to S_FLT.
  - Once confirmed, hs_status is not rechecked while in S_HS.
- S_DT_L and S_LS: mirror images of S_DT_H and S_HS, with HS/LS swapped and fetin inverted.
- S_FLT: both gates 0. fault_clr=1 moves to S_OFF on the next edge; otherwise stay. fault_clr is ignored in all other states.
- Channels are fully independent. Only en and fault_clr are shared.
- Reset asserted mid-operation: gates drop asynchronously; no dead-time is applied on release.

Decomposition:
- Package fetdriver_seq_pkg holds the state enum fet_state_t (6 states, 3-bit encoding) and the localparam helper for CNT_W.
- Natural sub-module: fetdriver_seq_ch, one channel containing its FSM, counter and 2 synchronisers. The top instantiates NUM_CH copies via generate, builds the en AND, and reduces busy.

Test Plan:
1. Reset with random inputs -> gate_hs, gate_ls, fault and busy all 0 during reset and 1 cycle after release.
2. en=1, ch0 in S_LS, ideal sense model (status = gate, 0 delay); fetin[0] rises -> gate_ls falls next edge, gate_hs rises exactly 4 cycles after gate_ls falls, busy=1 for those 4 cycles.
3. gate_status_ls[0] stuck at 1, fetin[0] 0->1 -> gate_ls=0, gate_hs stays 0, fault[0]=1 exactly 16 cycles after entering S_DT_H; ch1 keeps toggling normally.
4. In S_HS, gate_status_hs[0] stuck 0 -> fault[0]=1 at 16 cycles after gate_hs rises; gate_hs=0 on that same edge.
5. global_fetdriver drops while ch0 in S_HS -> gate_hs=0 next edge. Re-enable with fetin=1 -> gate_hs returns only after the 4-cycle dead-time.
6. fault[0]=1, then en=0 -> fault stays 1; fault_clr pulse -> fault=0 next edge and S_OFF. With en=1, normal sequencing resumes.
